// File: rtl/raycast_draw_pkg.sv
// Shared definitions for the raycaster drawing blocks: FSM state encoding,
// screen geometry defaults, the palette and the wall-height clamp helper.
package raycast_draw_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] CEIL_COLOUR  = 3'b001;
    localparam logic [2:0] WALL_COLOUR  = 3'b100;
    localparam logic [2:0] FLOOR_COLOUR = 3'b010;
    localparam logic [2:0] SHADE_COLOUR = 3'b101;

    // A projected height taller than the screen is drawn as a full-height wall.
    function automatic logic [6:0] clamp_height(input logic [6:0] size, input logic [6:0] limit);
        logic [6:0] h;
        if (size > limit) begin
            h = limit;
        end else begin
            h = size;
        end
        return h;
    endfunction

endpackage

// File: rtl/draw_column_slice_bounds.sv
// slice_bounds: combinational vertical placement of one wall slice.
// Produces the first wall row (top) and the exclusive last wall row (bot).
module slice_bounds #(
    parameter int SCREEN_H = raycast_draw_pkg::SCREEN_H
) (
    input  logic [6:0] i_slice_size,
    output logic [6:0] o_top,
    output logic [6:0] o_bot
);
    import raycast_draw_pkg::*;

    logic [6:0] w_h;
    logic [6:0] w_space;

    // Centre the clamped wall; the odd leftover row falls to the floor.
    always_comb begin
        w_h     = clamp_height(i_slice_size, 7'(SCREEN_H));
        w_space = 7'(SCREEN_H) - w_h;
        o_top   = {1'b0, w_space[6:1]};
        o_bot   = o_top + w_h;
    end

endmodule

// File: rtl/draw_column_slice.sv
// draw_column_slice: plots one screen column (ceiling, wall, floor) into the
// VGA adapter, one pixel per clock. Build option WALL_SHADE_EN enables side shading.
module draw_column_slice #(
    parameter int SCREEN_W = raycast_draw_pkg::SCREEN_W,
    parameter int SCREEN_H = raycast_draw_pkg::SCREEN_H
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] column,
    input  logic [6:0] slice_size,
    input  logic       wall_side,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    import raycast_draw_pkg::*;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_y_cnt;
    logic [6:0] r_top;
    logic [6:0] r_bot;
    logic [6:0] r_size;
    logic [7:0] r_col;
    logic [6:0] w_top;
    logic [6:0] w_bot;
    logic       w_last;
    logic [2:0] w_wall_colour;

    slice_bounds #(.SCREEN_H(SCREEN_H)) u_bounds (
        .i_slice_size (r_size),
        .o_top        (w_top),
        .o_bot        (w_bot)
    );

    assign w_last = (r_y_cnt == 7'(SCREEN_H - 1));

`ifdef WALL_SHADE_EN
    logic r_side;

    // Wall side is captured with the column so it cannot change mid-draw.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_side <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_side <= wall_side;
        end
    end

    assign w_wall_colour = r_side ? SHADE_COLOUR : WALL_COLOUR;
`else
    logic w_unused_side;
    assign w_unused_side = wall_side;
    assign w_wall_colour = WALL_COLOUR;
`endif

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Column latch, bounds capture and row counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_y_cnt <= 7'd0;
            r_top   <= 7'd0;
            r_bot   <= 7'd0;
            r_size  <= 7'd0;
            r_col   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_col  <= column;
                        r_size <= slice_size;
                    end
                end
                S_LOAD: begin
                    r_top   <= w_top;
                    r_bot   <= w_bot;
                    r_y_cnt <= 7'd0;
                end
                S_DRAW: begin
                    if (!w_last) begin
                        r_y_cnt <= r_y_cnt + 7'd1;
                    end
                end
                default: begin
                    r_y_cnt <= r_y_cnt;
                end
            endcase
        end
    end

    // Next-state decode; an off-screen column skips straight to completion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LOAD: begin
                if (r_col >= 8'(SCREEN_W)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DRAW;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Adapter outputs, decoded from state and registers only.
    always_comb begin
        plot       = 1'b0;
        done       = 1'b0;
        busy       = (r_state != S_IDLE);
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'b000;
        case (r_state)
            S_DRAW: begin
                plot  = 1'b1;
                vga_x = r_col;
                vga_y = r_y_cnt;
                if (r_y_cnt < r_top) begin
                    vga_colour = CEIL_COLOUR;
                end else if (r_y_cnt < r_bot) begin
                    vga_colour = w_wall_colour;
                end else begin
                    vga_colour = FLOOR_COLOUR;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                plot = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_draw_column_slice.sv
// Scoreboard bench for draw_column_slice: a geometry model queues expected
// pixels and done pulses; a negedge monitor pops and compares them.
module tb_draw_column_slice;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] column = 8'd0;
    logic [6:0] slice_size = 7'd0;
    logic       wall_side = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } pix_t;

    pix_t px_q[$];
    int   done_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    draw_column_slice dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .column     (column),
        .slice_size (slice_size),
        .wall_side  (wall_side),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected picture of one column; c0 is the cycle count just before the accepting edge.
    task automatic push_model(input int col, input int sz, input int side, input int c0);
        int h;
        int top;
        int bot;
        int wallc;
        pix_t p;
        if (col >= 160) begin
            done_q.push_back(c0 + 2);
            return;
        end
        h = (sz > 120) ? 120 : sz;
        top = (120 - h) / 2;
        bot = top + h;
`ifdef WALL_SHADE_EN
        wallc = side ? 5 : 4;
`else
        wallc = 4;
`endif
        for (int y = 0; y < 120; y++) begin
            p.x = col;
            p.y = y;
            p.c = (y < top) ? 1 : ((y < bot) ? wallc : 2);
            p.t = c0 + 2 + y;
            px_q.push_back(p);
        end
        done_q.push_back(c0 + 122);
    endtask

    always @(negedge clock) begin : monitor
        pix_t p;
        int   t;
        if (plot) begin
            if (px_q.size() == 0) begin
                check("unexpected_plot", 1, 0);
            end else begin
                p = px_q.pop_front();
                check("pix_x", int'(vga_x), p.x);
                check("pix_y", int'(vga_y), p.y);
                check("pix_colour", int'(vga_colour), p.c);
                check("pix_cycle", cyc, p.t);
            end
        end else begin
            check("idle_outputs_zero", int'({vga_x, vga_y, vga_colour}), 0);
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                t = done_q.pop_front();
                check("done_cycle", cyc, t);
            end
        end
    end

    task automatic run_col(input int col, input int sz, input int side,
                           input int restart_at, input int reset_at);
        int c0;
        bit got;
        @(negedge clock);
        column     = 8'(col);
        slice_size = 7'(sz);
        wall_side  = side[0];
        start      = 1'b1;
        c0         = cyc;
        push_model(col, sz, side, c0);
        @(negedge clock);
        start      = 1'b0;
        column     = 8'($urandom);
        slice_size = 7'($urandom);
        wall_side  = 1'($urandom);
        check("busy_after_accept", int'(busy), 1);
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (done) begin
                check("busy_at_done", int'(busy), 1);
                got = 1'b1;
            end else begin
                start = (cyc == c0 + 2 + restart_at);
                if (cyc == c0 + 2 + reset_at) begin
                    #2 resetn = 1'b0;
                    #1;
                    check("reset_drops_plot", int'(plot), 0);
                    check("reset_drops_busy", int'(busy), 0);
                    check("reset_no_done", int'(done), 0);
                    px_q.delete();
                    done_q.delete();
                    @(negedge clock);
                    resetn = 1'b1;
                    got = 1'b1;
                end else begin
                    @(negedge clock);
                end
            end
        end
        start = 1'b0;
        if (!got) begin
            check("done_timeout", 0, 1);
        end
        @(negedge clock);
        check("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        resetn = 1'b0;
        #12;
        check("reset_plot", int'(plot), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_vga", int'({vga_x, vga_y, vga_colour}), 0);
        @(negedge clock);
        resetn = 1'b1;

        run_col(10, 40, 0, 1000, 1000);
        run_col(10, 40, 1, 1000, 1000);
        run_col(10, 0, 0, 1000, 1000);
        run_col(10, 127, 0, 1000, 1000);
        run_col(10, 41, 1, 1000, 1000);
        run_col(200, 50, 0, 1000, 1000);
        run_col(160, 50, 0, 1000, 1000);
        run_col(159, 120, 1, 1000, 1000);
        run_col(20, 70, 0, 50, 1000);
        run_col(30, 90, 1, 1000, 70);
        run_col(40, 33, 0, 1000, 1000);
        for (int i = 0; i < 8; i++) begin
            run_col(int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 1)), 1000, 1000);
        end

        repeat (3) @(negedge clock);
        check("pixel_queue_drained", px_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
